qsys_led_pio: RTL and testbench

QSYS_LED_PIO -- requirements
Module: qsys_led_pio

---
 rtl/qsys_pio_pkg.sv | 15 +
 rtl/qsys_led_pio_if.sv | 21 ++
 rtl/blink_timer.sv | 54 +++++
 rtl/qsys_led_pio.sv | 98 +++++++++
 tb/tb_qsys_led_pio.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/qsys_pio_pkg.sv
// Shared definitions for the LED PIO slave: bus widths and the register map.
package qsys_pio_pkg;

    localparam int ADDR_W = 3;
    localparam int BUS_W  = 32;

    // Avalon-MM word addresses of the PIO registers; 6 and 7 are unmapped.
    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_MASK     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLEAR = 3'd5;

endpackage

// File: rtl/qsys_led_pio_if.sv
// Avalon-MM slave port bundle for the LED PIO; clock and reset stay outside.
interface qsys_led_pio_if;
    import qsys_pio_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [BUS_W-1:0]  writedata;
    logic [BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/blink_timer.sv
// Blink period down-counter and phase toggle. 'period' carries the value in
// force this cycle (the new value when 'load' is high); phase toggles every
// 'period' cycles and sits at 0 while the period is zero.
module blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                load,
    output logic                phase
);

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] reload;
    logic                phase_q, phase_d;

    // A zero period reloads 0 so the counter rests at 0 while disabled.
    assign reload = (period == '0) ? '0 : period - ONE;

    // Next counter/phase: a period write restarts the cycle and wins over expiry.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = reload;
            phase_d = 1'b0;
        end else if (period == '0) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d   = reload;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q - ONE;
        end
    end

    // Counter and phase registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/qsys_led_pio.sv
// LED PIO slave: DATA/MASK/PERIOD registers, set/clear strobes, registered
// read port and a blinking LED output driven as DATA ^ (MASK & phase).
module qsys_led_pio
    import qsys_pio_pkg::*;
#(
    parameter int               WIDTH       = 10,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               PERIOD_W    = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    qsys_led_pio_if.slave    bus,
    output logic [WIDTH-1:0] out_port
);

    logic                wr_en;
    logic [WIDTH-1:0]    wdata;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic                period_wr;
    logic                phase;
    logic [BUS_W-1:0]    readdata_q, readdata_d;
    logic [WIDTH-1:0]    out_q, out_d;
    logic                unused_wd;

    assign wr_en     = bus.chipselect & ~bus.write_n;
    assign wdata     = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    // Register writes; OUTSET/OUTCLEAR modify DATA bitwise, unmapped writes are dropped.
    always_comb begin
        data_d    = data_q;
        mask_d    = mask_q;
        period_d  = period_q;
        period_wr = 1'b0;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = wdata;
                ADDR_MASK:     mask_d = wdata;
                ADDR_PERIOD: begin
                    period_d  = bus.writedata[PERIOD_W-1:0];
                    period_wr = 1'b1;
                end
                ADDR_OUTSET:   data_d = data_q | wdata;
                ADDR_OUTCLEAR: data_d = data_q & ~wdata;
                default:       ;
            endcase
        end
    end

    // Read mux built from current register values, so a same-cycle write reads old data.
    always_comb begin
        case (bus.address)
            ADDR_DATA:   readdata_d = BUS_W'(data_q);
            ADDR_MASK:   readdata_d = BUS_W'(mask_q);
            ADDR_PERIOD: readdata_d = BUS_W'(period_q);
            ADDR_STATUS: readdata_d = BUS_W'(phase);
            default:     readdata_d = '0;
        endcase
    end

    // LED drive: masked bits follow the blink phase.
    always_comb begin
        out_d = data_q ^ (mask_q & {WIDTH{phase}});
    end

    blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .period  (period_d),
        .load    (period_wr),
        .phase   (phase)
    );

    // Architectural and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= RESET_VALUE;
            mask_q     <= '0;
            period_q   <= '0;
            readdata_q <= '0;
            out_q      <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            mask_q     <= mask_d;
            period_q   <= period_d;
            readdata_q <= readdata_d;
            out_q      <= out_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign out_port     = out_q;

endmodule

// File: tb/tb_qsys_led_pio.sv
// Self-checking bench for qsys_led_pio: a table of single bus cycles with
// expected readdata/out_port, then hand-written blink, period-collision,
// period-disable and mid-blink reset sequences.
module tb_qsys_led_pio;
    import qsys_pio_pkg::*;

    localparam int W = 10;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] out_port;

    qsys_led_pio_if bus ();

    qsys_led_pio #(
        .WIDTH       (W),
        .RESET_VALUE (10'h000),
        .PERIOD_W    (24)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int           tag;
        logic [31:0]  rd;
        logic [W-1:0] out;
    } exp_t;

    typedef struct {
        logic [2:0]   a;
        logic         cs;
        logic         wn;
        logic [31:0]  wd;
        logic [31:0]  rd;
        logic [W-1:0] out;
    } vec_t;

    exp_t sb[$];
    vec_t vt[21];
    int   total = 0;
    int   bad   = 0;
    int   tagn  = 0;

    // Monitor: pops one expectation per clock, sampled 1 time unit after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total++;
                if (bus.readdata !== e.rd) begin
                    bad++;
                    $display("FAIL readdata step=%0d got=0x%0h want=0x%0h", e.tag, bus.readdata, e.rd);
                end
                total++;
                if (out_port !== e.out) begin
                    bad++;
                    $display("FAIL out_port step=%0d got=0x%0h want=0x%0h", e.tag, out_port, e.out);
                end
            end
        end
    end

    // One bus cycle driven on the falling edge; expectation is for the next rising edge.
    task automatic cyc(input logic rn, input logic [2:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic [31:0] erd, input logic [W-1:0] eout);
        exp_t e;
        @(negedge clk);
        reset_n        = rn;
        bus.address    = a;
        bus.chipselect = cs;
        bus.write_n    = wn;
        bus.writedata  = wd;
        e.tag = tagn;
        e.rd  = erd;
        e.out = eout;
        tagn++;
        sb.push_back(e);
    endtask

    // STATUS reads k0..k1 cycles after a period-P load: the read at cycle k
    // sees the phase left by cycle k-1, which is ((k-1)/P) mod 2.
    task automatic blink_reads(input int p, input int k0, input int k1,
                               input logic [W-1:0] data, input logic [W-1:0] mask);
        int ph;
        for (int k = k0; k <= k1; k++) begin
            ph = ((k - 1) / p) % 2;
            cyc(1'b1, ADDR_STATUS, 1'b1, 1'b1, 32'h0, 32'(ph), data ^ (ph != 0 ? mask : '0));
        end
    endtask

    initial begin
        int w;
        reset_n        = 1'b0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;

        //           addr         cs    wn    writedata      readdata      out_port
        vt[0]  = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[1]  = '{ADDR_DATA,     1'b1, 1'b0, 32'h3FF,       32'h0,        10'h000};
        vt[2]  = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h3FF,      10'h3FF};
        vt[3]  = '{ADDR_OUTCLEAR, 1'b1, 1'b0, 32'h00F,       32'h0,        10'h3FF};
        vt[4]  = '{ADDR_OUTSET,   1'b1, 1'b0, 32'h001,       32'h0,        10'h3F0};
        vt[5]  = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h3F1,      10'h3F1};
        vt[6]  = '{ADDR_MASK,     1'b1, 1'b0, 32'h003,       32'h0,        10'h3F1};
        vt[7]  = '{ADDR_MASK,     1'b1, 1'b1, 32'h0,         32'h3,        10'h3F1};
        vt[8]  = '{ADDR_DATA,     1'b0, 1'b0, 32'h2AA,       32'h3F1,      10'h3F1};
        vt[9]  = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h3F1,      10'h3F1};
        vt[10] = '{ADDR_DATA,     1'b1, 1'b0, 32'hFFFFFC00,  32'h3F1,      10'h3F1};
        vt[11] = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[12] = '{ADDR_MASK,     1'b1, 1'b0, 32'hFFFFFFFC,  32'h3,        10'h000};
        vt[13] = '{ADDR_MASK,     1'b1, 1'b1, 32'h0,         32'h3FC,      10'h000};
        vt[14] = '{ADDR_MASK,     1'b1, 1'b0, 32'h003,       32'h3FC,      10'h000};
        vt[15] = '{3'd6,          1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[16] = '{3'd7,          1'b1, 1'b0, 32'hFFFFFFFF,  32'h0,        10'h000};
        vt[17] = '{ADDR_DATA,     1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[18] = '{ADDR_STATUS,   1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[19] = '{ADDR_PERIOD,   1'b1, 1'b1, 32'h0,         32'h0,        10'h000};
        vt[20] = '{ADDR_PERIOD,   1'b1, 1'b0, 32'hFF000004,  32'h0,        10'h000};

        // Reset state.
        cyc(1'b0, ADDR_DATA, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        cyc(1'b0, ADDR_DATA, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);

        // Register map, set/clear, truncation, unmapped addresses; last row loads PERIOD=4.
        for (int i = 0; i < 21; i++)
            cyc(1'b1, vt[i].a, vt[i].cs, vt[i].wn, vt[i].wd, vt[i].rd, vt[i].out);

        // Blink with MASK=3, DATA=0, PERIOD=4.
        blink_reads(4, 1, 19, 10'h000, 10'h003);

        // PERIOD=6 written in the cycle the counter expires (phase would go 0->1).
        cyc(1'b1, ADDR_PERIOD, 1'b1, 1'b0, 32'd6, 32'd4, 10'h000);
        blink_reads(6, 1, 8, 10'h000, 10'h003);

        // PERIOD=0 while phase=1: phase drops, out_port returns to DATA.
        cyc(1'b1, ADDR_PERIOD, 1'b1, 1'b0, 32'd0, 32'd6, 10'h003);
        for (int i = 0; i < 6; i++)
            cyc(1'b1, ADDR_STATUS, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        cyc(1'b1, ADDR_PERIOD, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);

        // Reset pulse in the middle of a PERIOD=2 blink.
        cyc(1'b1, ADDR_DATA, 1'b1, 1'b0, 32'h100, 32'h0, 10'h000);
        cyc(1'b1, ADDR_PERIOD, 1'b1, 1'b0, 32'd2, 32'h0, 10'h100);
        blink_reads(2, 1, 3, 10'h100, 10'h003);
        cyc(1'b0, ADDR_STATUS, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        cyc(1'b1, ADDR_DATA, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        cyc(1'b1, ADDR_MASK, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        cyc(1'b1, ADDR_PERIOD, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);
        for (int i = 0; i < 8; i++)
            cyc(1'b1, ADDR_STATUS, 1'b1, 1'b1, 32'h0, 32'h0, 10'h000);

        // Drain the scoreboard with a bounded wait.
        w = 0;
        while (sb.size() != 0 && w < 10) begin
            @(posedge clk);
            #2;
            w++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
